// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Frame-level scan controller for the receive chain (beamformer -> envelope
// detector -> log compressor). Fires one start pulse per scan line while
// holding a minimum pulse-repetition interval. It counts the compressed samples
// returned for each line, then advances the line index and flags frame
// completion. A sample that arrives outside the acquisition window raises a
// sticky overrun flag.
//
// Optional feature: define SCANSEQ_TIMEOUT_EN to build an ACQUIRE watchdog.
// The watchdog forces line completion after TIMEOUT_CYCLES idle cycles and
// sets timeout_err. Without the macro the watchdog is absent and timeout_err
// is tied to 0.
//
// Ports:
//   clk          in   single clock
//   reset        in   asynchronous, active-high reset
//   enable       in   run request (level); sampled in IDLE and FRAME_END
//   abort        in   synchronous stop to IDLE; overrides enable
//   sample_valid in   one compressed sample accepted downstream
//   start_pulse  out  one-cycle fire strobe to the beamformer
//   line_idx     out  current line number [LW]
//   sample_idx   out  samples received so far in the current line [SW]
//   line_active  out  high while in ACQUIRE
//   frame_done   out  one-cycle strobe after the last sample of the last line
//   frame_count  out  completed frames, wraps 65535 -> 0
//   busy         out  high in any state other than IDLE
//   overrun      out  sticky: a sample arrived outside ACQUIRE
//   timeout_err  out  sticky watchdog flag (0 without SCANSEQ_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module scan_sequencer #(
    parameter int NUM_LINES        = 128,
    parameter int SAMPLES_PER_LINE = 1024,
    parameter int PRF_DIV          = 5000,
    parameter int TIMEOUT_CYCLES   = 65535,
    localparam int LW = $clog2(NUM_LINES),
    localparam int SW = $clog2(SAMPLES_PER_LINE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          abort,
    input  logic          sample_valid,
    output logic          start_pulse,
    output logic [LW-1:0] line_idx,
    output logic [SW-1:0] sample_idx,
    output logic          line_active,
    output logic          frame_done,
    output logic [15:0]   frame_count,
    output logic          busy,
    output logic          overrun,
    output logic          timeout_err
);

    localparam int PW = $clog2(PRF_DIV);
    localparam logic [PW-1:0] PRF_LAST    = PW'(PRF_DIV - 1);
    localparam logic [LW-1:0] LINE_LAST   = LW'(NUM_LINES - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_LINE - 1);

    // Elaboration-time parameter range check.
    if (NUM_LINES < 2 || SAMPLES_PER_LINE < 2 || PRF_DIV < 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("scan_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_ACQUIRE,
        S_WAIT_PRF,
        S_FRAME_END
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prf_cnt;     // cycles since the last FIRE, saturating
    logic          wd_expire;   // watchdog forces the line to complete
    logic          last_sample;
    logic          line_done;
    logic          last_line;

    assign last_sample = sample_valid && (sample_idx == SAMPLE_LAST);
    assign line_done   = (state == S_ACQUIRE) && (last_sample || wd_expire);
    assign last_line   = (line_idx == LINE_LAST);

    always_comb begin
        // NOTE: default assignment first so every path assigns state_next; a
        // missed branch in combinational logic would otherwise infer a latch.
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (enable) state_next = S_FIRE;
                S_FIRE:      state_next = S_ACQUIRE;
                S_ACQUIRE:   if (line_done) state_next = last_line ? S_FRAME_END : S_WAIT_PRF;
                S_WAIT_PRF:  if (prf_cnt == PRF_LAST) state_next = S_FIRE;
                // The interval is still honoured across a frame boundary.
                S_FRAME_END: state_next = enable ? S_WAIT_PRF : S_IDLE;
                default:     state_next = S_IDLE;
            endcase
        end
    end

    // State and all strobes/flags are registered from the next-state decision,
    // so each output is glitch-free and aligned with the state it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            start_pulse <= 1'b0;
            line_active <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            prf_cnt     <= '0;
            line_idx    <= '0;
            sample_idx  <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values regardless of statement order.
            state       <= state_next;
            start_pulse <= (state_next == S_FIRE);
            line_active <= (state_next == S_ACQUIRE);
            frame_done  <= (state_next == S_FRAME_END);
            busy        <= (state_next != S_IDLE);

            // Zero during the FIRE cycle, so prf_cnt reaches PRF_DIV-1 exactly
            // PRF_DIV-1 cycles later and the next FIRE lands PRF_DIV after it.
            if (state_next == S_FIRE)
                prf_cnt <= '0;
            else if (prf_cnt != PRF_LAST)
                prf_cnt <= prf_cnt + PW'(1);

            if (abort) begin
                line_idx   <= '0;
                sample_idx <= '0;
                overrun    <= 1'b0;
            end else begin
                if (sample_valid && state != S_ACQUIRE)
                    overrun <= 1'b1;

                if (state_next == S_FIRE)
                    sample_idx <= '0;
                else if (state == S_ACQUIRE && sample_valid)
                    sample_idx <= sample_idx + SW'(1);

                if (line_done) begin
                    if (last_line) begin
                        line_idx    <= '0;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        line_idx <= line_idx + LW'(1);
                    end
                end
            end
        end
    end

`ifdef SCANSEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wd_cnt;

    // A sample arriving on the expiry cycle wins: it is a real sample.
    assign wd_expire = (state == S_ACQUIRE) && !sample_valid && (wd_cnt == WD_LAST);

    // Held at zero outside ACQUIRE, so it starts from zero on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (abort)
                timeout_err <= 1'b0;
            else if (wd_expire)
                timeout_err <= 1'b1;

            if (state != S_ACQUIRE || sample_valid)
                wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)
                wd_cnt <= wd_cnt + WW'(1);
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Frame-level scan controller for the receive chain (beamformer → envelope detector → log compressor). It replaces the free-running start pulse source with a sequenced one, doing four things:
- Issues one `start_pulse` per scan line and enforces a minimum pulse-repetition interval.
- Counts compressed samples returned per line.
- Advances the line index and signals frame completion.
- Flags samples that arrive outside an acquisition window.

## Interface
Parameters:
- `NUM_LINES`, 128, scan lines per frame (≥2)
- `SAMPLES_PER_LINE`, 1024, compressed samples expected per line (≥2)
- `PRF_DIV`, 5000, minimum clk cycles between consecutive `start_pulse` (≥3)
- `TIMEOUT_CYCLES`, 65535, max idle cycles in ACQUIRE before forced line completion (used only with `SCANSEQ_TIMEOUT_EN`)

Ports (LW = $clog2(NUM_LINES), SW = $clog2(SAMPLES_PER_LINE)):
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high reset
- `enable` in 1: run request; level sensitive
- `abort` in 1: synchronous stop; overrides `enable`
- `sample_valid` in 1: one compressed sample accepted downstream (log compressor output valid)
- `start_pulse` out 1: one-cycle fire strobe to the beamformer
- `line_idx` out LW: current line number
- `sample_idx` out SW: samples received so far in the current line
- `line_active` out 1: high in ACQUIRE
- `frame_done` out 1: one-cycle strobe after the last sample of the last line
- `frame_count` out 16: completed frames, wraps at 65535→0
- `busy` out 1: high in any state other than IDLE
- `overrun` out 1: sticky; a sample arrived outside ACQUIRE
- `timeout_err` out 1: sticky watchdog flag; constant 0 without the macro

## Operation
States: IDLE, FIRE, ACQUIRE, WAIT_PRF, FRAME_END.

- **IDLE**
  - `enable`=1 && `abort`=0 → FIRE.
- **FIRE** (1 cycle)
  - `start_pulse`=1.
  - `prf_cnt` loads 0; `sample_idx` loads 0.
  - Next state → ACQUIRE.
- **`prf_cnt`**
  - Increments every cycle after FIRE.
  - Saturates at PRF_DIV-1.
- **ACQUIRE**
  - Each `sample_valid` increments `sample_idx`.
  - `sample_valid` while `sample_idx`==SAMPLES_PER_LINE-1 completes the line.
  - If `line_idx`==NUM_LINES-1 → FRAME_END.
  - Otherwise `line_idx`+1 and → WAIT_PRF.
- **WAIT_PRF** (≥1 cycle)
  - `prf_cnt`==PRF_DIV-1 → FIRE.
- **FRAME_END** (1 cycle)
  - `frame_done`=1, `frame_count`+1, `line_idx`→0.
  - `enable`=1 → WAIT_PRF (interval still honoured); `enable`=0 → IDLE.
- **Deasserting `enable` mid-frame**: has no effect until FRAME_END. Frames always finish unless aborted.
- **`abort`=1 in any state**:
  - Next state IDLE.
  - `line_idx`, `sample_idx` and `overrun` cleared.
  - No `frame_done`; `frame_count` unchanged.
  - Held in IDLE while `abort` stays high.
- **`sample_valid` outside ACQUIRE**: ignored for counting and sets `overrun`.
- **FIRE vs. FRAME_END**: never coincide; states are exclusive.

## Timing
- Reset values: state IDLE; every output 0, including `frame_count`, `overrun` and `timeout_err`.
- First FIRE: `enable` sampled high at edge N → `start_pulse` high during cycle N+1.
- `start_pulse` spacing is exactly PRF_DIV when each line completes by PRF_DIV-2 cycles after FIRE. Otherwise spacing is line completion + 2 cycles (through one WAIT_PRF cycle).
- `line_idx` updates on the edge that completes the line and is stable through the following FIRE and ACQUIRE.
- `sample_idx` is registered: it shows the count before the current cycle's `sample_valid`.
- `frame_done` falls one cycle after the completing edge.
- Reset asserted mid-operation clears state immediately, asynchronously.

## Configuration
- `SCANSEQ_TIMEOUT_EN` defined:
  - A watchdog reloads to 0 on entering ACQUIRE and on each `sample_valid`, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 in ACQUIRE, `timeout_err` sets and the line completes exactly as if the final sample had arrived (normal advance or FRAME_END).
  - `abort` clears `timeout_err`.
- Undefined:
  - No watchdog logic; ACQUIRE waits indefinitely.
  - `timeout_err` tied to 0.

## Test plan
All scenarios use NUM_LINES=4, SAMPLES_PER_LINE=8, PRF_DIV=20, TIMEOUT_CYCLES=16.
- **Fast samples**: after reset, raise `enable`; feed 8 `sample_valid` per line promptly → `start_pulse` at cycles 1, 21, 41, 61; `line_idx` 0..3; one `frame_done`; `frame_count`=1; next `start_pulse` 20 cycles after the previous one.
- **Slow samples**: feed one sample every 5 cycles → line completes 40 cycles after FIRE; next `start_pulse` 2 cycles later; `overrun`=0.
- **Stop at frame boundary**: drop `enable` during line 1 → lines 2–3 still fire; `frame_done` pulses; then IDLE with `busy`=0.
- **Abort**: pulse `abort` in ACQUIRE of line 2 with `sample_idx`=3 → next cycle IDLE; `line_idx`=0; no `frame_done`; `frame_count` unchanged.
- **Stray sample**: `sample_valid` during WAIT_PRF → `overrun`=1, `sample_idx` unchanged; cleared only by `abort` or `reset`.
- **Timeout** (with `SCANSEQ_TIMEOUT_EN`): send 3 samples, then none → 16 cycles after the last sample `timeout_err`=1 and `line_idx` advances. Without the macro the sequencer stays in ACQUIRE and `timeout_err`=0.
